// File: rtl/pulse_burst_tx.sv
// pulse_burst_tx
// Transmit side of the pulse-count link: on request it emits exactly n clean
// high pulses on the single-bit line `a`. Each pulse is high for HIGH_CYC
// cycles and is followed by a low phase of LOW_CYC cycles. The last pulse
// also gets this trailing low phase.
//
// Ports:
//   ck        in   clock, all state updates on the rising edge
//   rst       in   asynchronous, active-high reset (aborts any burst)
//   start     in   request strobe, sampled on rising ck
//   n         in   [N_W] pulses to send, sampled together with start
//   a         out  pulse line (registered)
//   busy      out  high while a burst is in progress (registered)
//   done      out  one-cycle completion strobe (registered)
//   remaining out  [N_W] pulses not yet completed in the current burst
//   state_dbg out  [2] current FSM state (IDLE=0, HIGH=1, LOW=2)
//
// Handshake: start/n form a request with valid-only semantics. A request is
// accepted on any edge where start=1 and the FSM is IDLE. busy=1 acts as
// "not ready": a start seen while busy is dropped and is not queued. n is
// sampled only on the accepting edge. The FSM is already IDLE while done=1,
// so a start in that cycle is accepted.
module pulse_burst_tx #(
  parameter int N_W      = 4,
  parameter int HIGH_CYC = 2,
  parameter int LOW_CYC  = 2,
  parameter int T_W      = 4
) (
  input  logic           ck,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] n,
  output logic           a,
  output logic           busy,
  output logic           done,
  output logic [N_W-1:0] remaining,
  output logic [1:0]     state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Terminal timer values. The phase lengths are at most 2^T_W, so the
  // terminal values fit in T_W bits and the timer never wraps inside a phase.
  localparam logic [T_W-1:0] HIGH_LAST = T_W'(HIGH_CYC - 1);
  localparam logic [T_W-1:0] LOW_LAST  = T_W'(LOW_CYC - 1);

  state_t         state_q, state_d;
  logic [T_W-1:0] timer_q, timer_d;
  logic [N_W-1:0] remaining_q, remaining_d;
  logic           a_q, a_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      remaining_q <= '0;
      a_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      remaining_q <= remaining_d;
      a_q         <= a_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    remaining_d = remaining_q;
    a_d         = a_q;
    busy_d      = busy_q;
    done_d      = 1'b0;  // done is a strobe and lasts one cycle only

    unique case (state_q)
      IDLE: begin
        a_d    = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          if (n != '0) begin
            remaining_d = n;
            timer_d     = '0;
            busy_d      = 1'b1;
            a_d         = 1'b1;
            state_d     = HIGH;
          end else begin
            // An empty request completes at once and sends no pulse.
            done_d = 1'b1;
          end
        end
      end

      HIGH: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == HIGH_LAST) begin
          a_d     = 1'b0;
          timer_d = '0;
          // A pulse counts as completed at its falling edge.
          if (remaining_q != '0) remaining_d = remaining_q - 1'b1;
          state_d = LOW;
        end
      end

      LOW: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == LOW_LAST) begin
          timer_d = '0;
          if (remaining_q != '0) begin
            a_d     = 1'b1;
            state_d = HIGH;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        a_d     = 1'b0;
        busy_d  = 1'b0;
        timer_d = '0;
      end
    endcase
  end

  assign a         = a_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = remaining_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pulse_burst_tx.sv
module tb_pulse_burst_tx;

  // ---------------- clock / reset ----------------
  logic       ck;
  logic       rst;
  logic       start, start_m;
  logic [3:0] n, n_m;
  logic       a, busy, done;
  logic [3:0] remaining;
  logic [1:0] state_dbg;
  logic       a_m, busy_m, done_m;
  logic [3:0] remaining_m;
  logic [1:0] state_dbg_m;

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Default timing instance: HIGH_CYC=2, LOW_CYC=2.
  pulse_burst_tx #(.N_W(4), .HIGH_CYC(2), .LOW_CYC(2), .T_W(4)) dut (
    .ck(ck), .rst(rst), .start(start), .n(n),
    .a(a), .busy(busy), .done(done), .remaining(remaining),
    .state_dbg(state_dbg)
  );

  // Max-count instance: HIGH_CYC=1, LOW_CYC=3.
  pulse_burst_tx #(.N_W(4), .HIGH_CYC(1), .LOW_CYC(3), .T_W(4)) dut_m (
    .ck(ck), .rst(rst), .start(start_m), .n(n_m),
    .a(a_m), .busy(busy_m), .done(done_m), .remaining(remaining_m),
    .state_dbg(state_dbg_m)
  );

  // ---------------- lab pulse counters (far end of the link) ----------------
  int   pulses, pulses_m, dones;
  logic a_prev, a_prev_m;
  initial begin
    pulses = 0; pulses_m = 0; dones = 0; a_prev = 1'b0; a_prev_m = 1'b0;
  end
  always @(posedge ck) begin
    if (a && !a_prev) pulses = pulses + 1;
    a_prev = a;
    if (done) dones = dones + 1;
  end
  always @(posedge ck) begin
    if (a_m && !a_prev_m) pulses_m = pulses_m + 1;
    a_prev_m = a_m;
  end

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  int n_cmp, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  // Wait (bounded) for done on the default instance; a timeout shows up as
  // a failed done check.
  task automatic wait_done(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      tick();
    end
    chk(tag, done, 1);
  endtask

  int rem_tab [12] = '{3, 3, 2, 2, 2, 2, 1, 1, 1, 1, 0, 0};
  int p0, d0, bc;

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; n = '0; start_m = 1'b0; n_m = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_a", a, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_remaining", remaining, 0);
    chk("rst_state", state_dbg, 0);
    chk("rst_state_m", state_dbg_m, 0);
    rst = 1'b0;
    tick();
    chk("idle_a", a, 0);

    // Basic burst n=3: a = 1,1,0,0 x3, busy for 12 cycles
    for (int p = 0; p < 3; p++) begin
      exp_q.push_back(1'b1); exp_q.push_back(1'b1);
      exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    end
    p0 = pulses;
    start = 1'b1; n = 4'd3;
    tick();
    start = 1'b0; n = '0;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("basic_a[%0d]", k), a, exp_q.pop_front());
      chk($sformatf("basic_busy[%0d]", k), busy, 1);
      chk($sformatf("basic_rem[%0d]", k), remaining, rem_tab[k]);
      chk($sformatf("basic_done[%0d]", k), done, 0);
      tick();
    end
    chk("basic_end_done", done, 1);
    chk("basic_end_busy", busy, 0);
    chk("basic_end_a", a, 0);
    chk("basic_end_rem", remaining, 0);
    chk("basic_end_state", state_dbg, 0);
    tick();
    chk("basic_done_1cyc", done, 0);
    chk("basic_pulses", pulses - p0, 3);

    // Zero request
    start = 1'b1; n = 4'd0;
    tick();
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_a", a, 0);
    tick();
    chk("zero_done_1cyc", done, 0);
    chk("zero_a2", a, 0);
    chk("zero_busy2", busy, 0);

    // Ignored start during an n=2 burst
    p0 = pulses;
    start = 1'b1; n = 4'd2;
    tick();
    start = 1'b0; n = '0;
    repeat (3) tick();            // k=3: LOW of pulse 1
    chk("ign_rem_before", remaining, 1);
    start = 1'b1; n = 4'd7;
    tick();                       // k=4: HIGH of pulse 2
    start = 1'b0; n = '0;
    chk("ign_rem_after", remaining, 1);
    chk("ign_a", a, 1);
    wait_done("ign_done_seen");
    chk("ign_pulses", pulses - p0, 2);
    repeat (4) tick();
    chk("ign_no_restart", busy, 0);

    // Back-to-back: start n=1 in the done cycle of an n=2 burst
    p0 = pulses; d0 = dones;
    start = 1'b1; n = 4'd2;
    tick();
    start = 1'b0; n = '0;
    wait_done("b2b_done1_seen");
    start = 1'b1; n = 4'd1;
    tick();
    start = 1'b0; n = '0;
    chk("b2b_a_next", a, 1);
    chk("b2b_busy_next", busy, 1);
    chk("b2b_rem_next", remaining, 1);
    chk("b2b_done_cleared", done, 0);
    wait_done("b2b_done2_seen");
    tick();
    chk("b2b_pulses", pulses - p0, 3);
    chk("b2b_dones", dones - d0, 2);

    // Asynchronous reset mid-HIGH of an n=5 burst
    p0 = pulses;
    start = 1'b1; n = 4'd5;
    tick();
    start = 1'b0; n = '0;
    tick();                       // k=1: still HIGH
    chk("ar_pre_a", a, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_a", a, 0);
    chk("ar_busy", busy, 0);
    chk("ar_remaining", remaining, 0);
    chk("ar_state", state_dbg, 0);
    #3 rst = 1'b0;
    repeat (20) tick();
    chk("ar_no_pulses", pulses - p0, 1);
    chk("ar_busy_after", busy, 0);

    // Max count and loopback on the HIGH_CYC=1 / LOW_CYC=3 instance
    p0 = pulses_m;
    start_m = 1'b1; n_m = 4'd15;
    tick();
    start_m = 1'b0; n_m = '0;
    chk("max_rem_start", remaining_m, 15);
    bc = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy_m) break;
      bc++;
      tick();
    end
    chk("max_busy_cycles", bc, 60);
    chk("max_done", done_m, 1);
    chk("max_rem_end", remaining_m, 0);
    chk("max_counter", pulses_m - p0, 15);
    tick();
    chk("max_done_1cyc", done_m, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_burst_tx.md
Name: pulse_burst_tx

Overview:
Transmit side of the pulse-count link. On request, the block emits exactly N clean high pulses on a single-bit line. The pulse counter at the far end tallies those pulses. It supplies the stimulus line (the counter's `a` input) for the lab counter exercises. It replaces hand-written `#delay` toggling with a clocked, handshaked generator.

Parameters:
N_W, 4, width of the pulse-count request and of the remaining counter
HIGH_CYC, 2, clock cycles per pulse high phase (legal range 1..2^T_W)
LOW_CYC, 2, clock cycles per pulse low phase (legal range 1..2^T_W)
T_W, 4, width of the internal phase timer

Ports:
ck  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request strobe, sampled on rising ck
n  input  N_W  number of pulses to send, sampled together with start
a  output  1  pulse line (registered)
busy  output  1  high while a burst is in progress (registered)
done  output  1  one-cycle strobe marking burst completion (registered)
remaining  output  N_W  pulses not yet completed in the current burst (registered)

Behaviour:
- Interface: one clock `ck`. Reset `rst` is asynchronous and active-high.
- Reset, asynchronous on `rst`=1 and independent of `ck`:
  - state goes to IDLE
  - `a`=0, `busy`=0, `done`=0, `remaining`=0, timer=0
- Reset mid-burst aborts the burst immediately.
- After `rst` falls, the first rising `ck` is a normal edge.
- The state machine has three states: IDLE, HIGH, LOW.
- IDLE:
  - `a`=0, `busy`=0.
  - On an edge with `start`=1 and `n`≠0: `remaining`←`n`, timer←0, `busy`←1, `a`←1, go to HIGH.
  - On an edge with `start`=1 and `n`=0: `done`←1 for one cycle, stay IDLE, `busy` stays 0, no pulse.
- HIGH:
  - `a`=1. Timer increments each edge.
  - On the edge where timer=HIGH_CYC-1: `a`←0, timer←0, `remaining`←`remaining`-1, go to LOW.
- LOW:
  - `a`=0. Timer increments each edge.
  - On the edge where timer=LOW_CYC-1 and `remaining`≠0: `a`←1, timer←0, go to HIGH.
  - On the edge where timer=LOW_CYC-1 and `remaining`=0: `busy`←0, `done`←1, go to IDLE.
- Latency and timing:
  - The first `a` high is visible in the cycle right after the edge that samples `start`.
  - `a` is high for exactly HIGH_CYC cycles per pulse and low for exactly LOW_CYC cycles between pulses.
  - A trailing LOW_CYC low phase follows the last pulse.
  - `busy` is high for exactly `n`·(HIGH_CYC+LOW_CYC) cycles.
  - `done` rises on the same edge where `busy` falls and lasts exactly 1 cycle.
- Handshake:
  - `start` while `busy`=1 is ignored. `n` changes during a burst have no effect.
  - `start`=1 in the cycle where `done`=1 is accepted, because the state is already IDLE. Back-to-back bursts therefore have no dead cycle beyond the trailing low phase.
- Arithmetic:
  - `remaining` is unsigned, N_W bits, and never decrements below 0.
  - `n`=2^N_W-1 (15 by default) is legal.
  - Timer width must hold HIGH_CYC-1 and LOW_CYC-1; no wrap occurs within a phase.
- HIGH_CYC=1 or LOW_CYC=1 gives single-cycle phases. There are no glitches, since `a` comes straight from a flop.

Test Plan:
- Reset: assert `rst` asynchronously mid-HIGH of a 5-pulse burst (`n`=5) -> `a`=0, `busy`=0, `remaining`=0 immediately, without waiting for a `ck` edge; after release, no further pulses.
- Basic burst, defaults: `start`=1 with `n`=3 for one cycle -> `a` reads 1,1,0,0 repeated 3 times; `busy` high 12 cycles; `remaining` steps 3→2→1→0 at each high-to-low edge; `done`=1 for 1 cycle when `busy` falls.
- Zero request: `start` with `n`=0 -> `done`=1 on the next cycle; `busy` and `a` stay 0.
- Ignored start: during an `n`=2 burst, pulse `start` with `n`=7 -> exactly 2 pulses; `remaining` unaffected.
- Back-to-back: assert `start` (`n`=1) in the `done` cycle of an `n`=2 burst -> the next `a` high starts in the following cycle; 3 pulses in total; 2 `done` strobes.
- Max count and loopback: `n`=15 with HIGH_CYC=1 and LOW_CYC=3, output fed to the lab pulse counter -> counter reads 15; `busy` lasts 60 cycles.
